// File: rtl/rv32i_inst_encoder.sv
// rv32i_inst_encoder: packs per-instruction fields (R-type, OP-IMM, JAL) into
// RV32I words and streams them, with incrementing byte addresses, through a
// single-entry valid/ready output register. Illegal requests become a NOP
// (addi x0,x0,0) and raise a sticky flag.
module rv32i_inst_encoder #(
  parameter int          ADDR_W    = 32,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_fmt,
  input  logic [7:0]        in_op,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_word,
  output logic [ADDR_W-1:0] out_addr,
  input  logic              flush,
  output logic              illegal,
  input  logic              clr_illegal,
  output logic [15:0]       word_cnt
);

  localparam logic [ADDR_W-1:0] BASE = BASE_ADDR[ADDR_W-1:0];
  localparam logic [ADDR_W-1:0] STEP = ADDR_W'(4);
  localparam logic [31:0]       NOP  = 32'h0000_0013;

  localparam logic [6:0] OPC_R = 7'b0110011;
  localparam logic [6:0] OPC_I = 7'b0010011;
  localparam logic [6:0] OPC_J = 7'b1101111;

  logic              r_out_valid;
  logic [31:0]       r_out_word;
  logic [ADDR_W-1:0] r_out_addr;
  logic [ADDR_W-1:0] r_next_addr;   // address the next loaded word receives
  logic              r_illegal;
  logic [15:0]       r_word_cnt;

  logic [2:0]        w_f3;
  logic [6:0]        w_f7;
  logic              w_op_ok;
  logic              w_is_shift;
  logic              w_imm12_ok;
  logic              w_shamt_ok;
  logic              w_jimm_ok;
  logic              w_legal;
  logic [31:0]       w_enc;
  logic [31:0]       w_word;
  logic              w_in_acc;
  logic              w_out_acc;
  logic [ADDR_W-1:0] w_next_inc;
  logic [ADDR_W-1:0] w_load_addr;

  assign in_ready  = !flush && (!r_out_valid || out_ready);
  assign w_in_acc  = in_valid && in_ready;
  assign w_out_acc = r_out_valid && out_ready;

  // While FULL the next-address register still equals out_addr, so a word
  // loaded in the same cycle as a delivery takes the incremented address.
  assign w_next_inc  = r_next_addr + STEP;
  assign w_load_addr = w_out_acc ? w_next_inc : r_next_addr;

  assign w_op_ok    = (in_op >= 8'h01) && (in_op <= 8'h0a);
  assign w_is_shift = (in_op == 8'h03) || (in_op == 8'h07) || (in_op == 8'h08);
  assign w_imm12_ok = (&in_imm[31:11]) || (~|in_imm[31:11]);
  assign w_shamt_ok = ~|in_imm[31:5];
  assign w_jimm_ok  = !in_imm[0] && ((&in_imm[31:20]) || (~|in_imm[31:20]));

  // Map decoder op numbering onto funct3/funct7.
  always_comb begin
    w_f3 = 3'b000;
    w_f7 = 7'b0000000;
    case (in_op)
      8'h01: w_f3 = 3'b000;
      8'h02: begin w_f3 = 3'b000; w_f7 = 7'b0100000; end
      8'h03: w_f3 = 3'b001;
      8'h04: w_f3 = 3'b010;
      8'h05: w_f3 = 3'b011;
      8'h06: w_f3 = 3'b100;
      8'h07: w_f3 = 3'b101;
      8'h08: begin w_f3 = 3'b101; w_f7 = 7'b0100000; end
      8'h09: w_f3 = 3'b110;
      8'h0a: w_f3 = 3'b111;
      default: w_f3 = 3'b000;
    endcase
  end

  // Format-specific packing and legality.
  always_comb begin
    w_enc   = NOP;
    w_legal = 1'b0;
    case (in_fmt)
      2'd0: begin
        w_enc   = {w_f7, in_rs2, in_rs1, w_f3, in_rd, OPC_R};
        w_legal = w_op_ok;
      end
      2'd1: begin
        if (w_is_shift) begin
          w_enc   = {w_f7, in_imm[4:0], in_rs1, w_f3, in_rd, OPC_I};
          w_legal = w_op_ok && w_shamt_ok;
        end else begin
          w_enc   = {in_imm[11:0], in_rs1, w_f3, in_rd, OPC_I};
          w_legal = w_op_ok && (in_op != 8'h02) && w_imm12_ok;
        end
      end
      2'd2: begin
        w_enc   = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, OPC_J};
        w_legal = (in_op == 8'h01) && w_jimm_ok;
      end
      default: begin
        w_enc   = NOP;
        w_legal = 1'b0;
      end
    endcase
  end

  assign w_word = w_legal ? w_enc : NOP;

  // Output register, address tracking and delivered-word counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_word  <= 32'h0;
      r_out_addr  <= BASE;
      r_next_addr <= BASE;
      r_word_cnt  <= 16'h0;
    end else if (flush) begin
      r_out_valid <= 1'b0;
      r_out_addr  <= BASE;
      r_next_addr <= BASE;
      r_word_cnt  <= 16'h0;
    end else begin
      if (w_out_acc) begin
        r_next_addr <= w_next_inc;
        if (r_word_cnt != 16'hFFFF) begin
          r_word_cnt <= r_word_cnt + 16'd1;
        end
      end
      if (w_in_acc) begin
        r_out_valid <= 1'b1;
        r_out_word  <= w_word;
        r_out_addr  <= w_load_addr;
      end else if (w_out_acc) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  // Sticky illegal flag; a new illegal accept beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_illegal <= 1'b0;
    end else if (w_in_acc && !w_legal) begin
      r_illegal <= 1'b1;
    end else if (clr_illegal) begin
      r_illegal <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_word  = r_out_word;
  assign out_addr  = r_out_addr;
  assign illegal   = r_illegal;
  assign word_cnt  = r_word_cnt;

endmodule

// File: doc/rv32i_inst_encoder.md
Name: rv32i_inst_encoder

Overview:
Encoder/loader that produces the instruction words our RV32I decoder consumes. It accepts per-instruction fields: format, ALU op in the decoder's op numbering, register addresses and a 32-bit immediate. It packs them into legal RV32I words covering R-type, OP-IMM and JAL, and streams the words with incrementing addresses toward instruction memory. It is used by the self-test/program-load path to build test programs in hardware.

Parameters:
ADDR_W, 32, width of out_addr; the address counter wraps modulo 2^ADDR_W.
BASE_ADDR, 0, first address after reset or flush; must be a multiple of 4.

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  input fields valid
in_ready  out  1  block can accept fields this cycle
in_fmt  in  2  0=R-type, 1=I-type (OP-IMM), 2=J-type (JAL), 3=reserved
in_op  in  8  ALU op: 0x01 add, 0x02 sub, 0x03 sll, 0x04 slt, 0x05 sltu, 0x06 xor, 0x07 srl, 0x08 sra, 0x09 or, 0x0a and
in_rd  in  5  destination register
in_rs1  in  5  source register 1
in_rs2  in  5  source register 2; R-type only
in_imm  in  32  immediate, two's complement
out_valid  out  1  out_word/out_addr valid
out_ready  in  1  downstream accepts word
out_word  out  32  encoded instruction
out_addr  out  ADDR_W  byte address of out_word
flush  in  1  synchronous: drop pending word, reload address to BASE_ADDR
illegal  out  1  sticky: an illegal request was substituted
clr_illegal  in  1  synchronous clear of illegal
word_cnt  out  16  words delivered since reset or flush; saturates at 0xFFFF

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_word=0, out_addr=BASE_ADDR, illegal=0, word_cnt=0, next address=BASE_ADDR. in_ready is 1 immediately after reset.
- Single-entry output register, two states:
  - EMPTY: out_valid=0.
  - FULL: out_valid=1.
- in_ready = !out_valid || out_ready, which allows a full-throughput pipeline.
- Input accept: in_valid && in_ready. Latency is 1 cycle: the encoded word appears on out_word with out_valid=1 on the next edge.
- Output accept: out_valid && out_ready. On each output accept:
  - the next address advances by 4, wrapping modulo 2^ADDR_W;
  - word_cnt increments and saturates at 0xFFFF.
- Accept of new fields and delivery of the old word in the same cycle: the register is reloaded, the state stays FULL, and the address of the new word is the old out_addr+4.
- While FULL && !out_ready: out_word and out_addr are held stable and in_ready=0.
- R encoding: {f7, rs2, rs1, f3, rd, 7'b0110011}.
  - f3 per op: add/sub 000, sll 001, slt 010, sltu 011, xor 100, srl/sra 101, or 110, and 111.
  - f7 = 7'b0100000 for sub and sra; 0 otherwise.
- I encoding: {imm[11:0], rs1, f3, rd, 7'b0010011}.
  - Shifts (sll/srl/sra) use {f7, imm[4:0], rs1, f3, rd, opcode} instead.
- J encoding (in_op must be 0x01): {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111}.
- Illegal requests:
  - in_fmt=3;
  - op 0x00 or op > 0x0a;
  - I-type with op 0x02;
  - J-type with op != 0x01;
  - I non-shift with imm outside [-2048, 2047];
  - I shift with imm[31:5] != 0;
  - J with imm[0]=1 or imm outside [-2^20, 2^20-2].
- Handling of an illegal request: it is still accepted and delivered, with out_word=32'h00000013 (addi x0,x0,0). illegal is set on the accept edge.
- clr_illegal clears illegal. If a set and a clear occur in the same cycle, the set wins.
- flush: on the next edge, out_valid=0, the next address and out_addr are reloaded to BASE_ADDR, and word_cnt=0. Any input presented that cycle is dropped and in_ready is forced to 0 during flush. flush does not clear illegal.
- Reset mid-transfer: the pending word is lost and all state returns to reset values asynchronously.

Test Plan:
- Reset, then R add rd=3 rs1=1 rs2=2 with out_ready=1 -> one cycle later out_word=0x002081B3, out_addr=0x0; the same fields with op 0x02 -> 0x402081B3 at addr 0x4; word_cnt=2.
- I addi rd=1 rs1=0 imm=-1 -> 0xFFF00093. I sra (srai) rd=5 rs1=6 imm=3 -> 0x40335293.
- J rd=1 imm=8 -> 0x008000EF. J imm=7 -> 0x00000013 and illegal=1. clr_illegal pulse -> illegal=0.
- Backpressure: hold out_ready=0 for 3 cycles with in_valid=1 -> out_word/out_addr stable and in_ready=0. Release -> back-to-back words at consecutive addresses, one per cycle.
- ADDR_W=4, 5 words -> addresses 0x0, 0x4, 0x8, 0xC, 0x0 (wrap).
- flush while FULL -> out_valid=0 next cycle, next word at BASE_ADDR, word_cnt=0.
- Assert rst_n low while FULL -> outputs return to reset values immediately, without waiting for a clock edge.
